// File: rtl/vx_cache_rsp_collector_if.sv
// Bundle between the issuer/cache side and the response collector: slot allocation,
// per-lane cache responses and the merged output response.
interface vx_cache_rsp_collector_if #(
    parameter int NUM_REQS       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLOTS      = 4,
    parameter int CORE_TAG_WIDTH = 8
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic                           alloc_valid_i;
    logic [NUM_REQS-1:0]            alloc_mask_i;
    logic [CORE_TAG_WIDTH-1:0]      alloc_tag_i;
    logic                           alloc_ready_o;
    logic [SLOT_W-1:0]              alloc_slot_o;

    logic [NUM_REQS-1:0]            rsp_valid_i;
    logic [NUM_REQS*DATA_WIDTH-1:0] rsp_data_i;
    logic [NUM_REQS*SLOT_W-1:0]     rsp_tag_i;
    logic [NUM_REQS-1:0]            rsp_ready_o;

    logic                           out_valid_o;
    logic [NUM_REQS-1:0]            out_mask_o;
    logic [NUM_REQS*DATA_WIDTH-1:0] out_data_o;
    logic [CORE_TAG_WIDTH-1:0]      out_tag_o;
    logic                           out_ready_i;

    logic                           err_o;

    modport master (
        output alloc_valid_i, alloc_mask_i, alloc_tag_i,
        output rsp_valid_i, rsp_data_i, rsp_tag_i,
        output out_ready_i,
        input  alloc_ready_o, alloc_slot_o, rsp_ready_o,
        input  out_valid_o, out_mask_o, out_data_o, out_tag_o, err_o
    );

    modport slave (
        input  alloc_valid_i, alloc_mask_i, alloc_tag_i,
        input  rsp_valid_i, rsp_data_i, rsp_tag_i,
        input  out_ready_i,
        output alloc_ready_o, alloc_slot_o, rsp_ready_o,
        output out_valid_o, out_mask_o, out_data_o, out_tag_o, err_o
    );
endinterface

// File: rtl/vx_cache_rsp_collector.sv
// Gathers out-of-order per-lane cache responses into preallocated request slots and
// emits one merged response per request once every requested lane has returned.
module vx_cache_rsp_collector #(
    parameter int NUM_REQS       = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLOTS      = 4,
    parameter int CORE_TAG_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    vx_cache_rsp_collector_if.slave  bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int LINE_W = NUM_REQS * DATA_WIDTH;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_state_e;

    slot_state_e               state_q [NUM_SLOTS];
    slot_state_e               state_d [NUM_SLOTS];
    logic [NUM_REQS-1:0]       mask_q  [NUM_SLOTS];
    logic [NUM_REQS-1:0]       mask_d  [NUM_SLOTS];
    logic [NUM_REQS-1:0]       rem_q   [NUM_SLOTS];
    logic [NUM_REQS-1:0]       rem_d   [NUM_SLOTS];
    logic [CORE_TAG_WIDTH-1:0] tag_q   [NUM_SLOTS];
    logic [CORE_TAG_WIDTH-1:0] tag_d   [NUM_SLOTS];
    logic [LINE_W-1:0]         data_q  [NUM_SLOTS];
    logic [LINE_W-1:0]         data_d  [NUM_SLOTS];

    logic                      out_valid_q, out_valid_d;
    logic [NUM_REQS-1:0]       out_mask_q, out_mask_d;
    logic [LINE_W-1:0]         out_data_q, out_data_d;
    logic [CORE_TAG_WIDTH-1:0] out_tag_q, out_tag_d;
    logic                      err_q, err_d;

    logic                      alloc_ready;
    logic [SLOT_W-1:0]         alloc_slot;
    logic                      alloc_fire;
    logic                      done_any;
    logic [SLOT_W-1:0]         done_slot;
    logic                      out_load;
    logic [SLOT_W-1:0]         rsp_slot;

    // Priority pick of the lowest FREE and lowest DONE slot, from registered state only.
    always_comb begin
        alloc_ready = 1'b0;
        alloc_slot  = '0;
        done_any    = 1'b0;
        done_slot   = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (state_q[s] == SLOT_FREE) begin
                alloc_ready = 1'b1;
                alloc_slot  = SLOT_W'(s);
            end
            if (state_q[s] == SLOT_DONE) begin
                done_any  = 1'b1;
                done_slot = SLOT_W'(s);
            end
        end
        alloc_fire = bus.alloc_valid_i & alloc_ready;
        out_load   = done_any & (~out_valid_q | bus.out_ready_i);
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        rem_d       = rem_q;
        tag_d       = tag_q;
        data_d      = data_q;
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        err_d       = err_q;
        rsp_slot    = '0;

        // Lanes are distinct, so several lanes may land in one slot without conflict.
        for (int i = 0; i < NUM_REQS; i++) begin
            if (bus.rsp_valid_i[i]) begin
                rsp_slot = bus.rsp_tag_i[i*SLOT_W +: SLOT_W];
                if (state_q[rsp_slot] == SLOT_PENDING && rem_q[rsp_slot][i]) begin
                    rem_d[rsp_slot][i] = 1'b0;
                    data_d[rsp_slot][i*DATA_WIDTH +: DATA_WIDTH] =
                        bus.rsp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (state_q[s] == SLOT_PENDING && rem_d[s] == '0) begin
                state_d[s] = SLOT_DONE;
            end
        end

        if (out_load) begin
            out_valid_d        = 1'b1;
            out_mask_d         = mask_q[done_slot];
            out_data_d         = data_q[done_slot];
            out_tag_d          = tag_q[done_slot];
            state_d[done_slot] = SLOT_FREE;
        end else if (bus.out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // The allocated slot was FREE, so neither the response nor the load path touched it.
        if (alloc_fire) begin
            state_d[alloc_slot] = (bus.alloc_mask_i == '0) ? SLOT_DONE : SLOT_PENDING;
            mask_d[alloc_slot]  = bus.alloc_mask_i;
            rem_d[alloc_slot]   = bus.alloc_mask_i;
            tag_d[alloc_slot]   = bus.alloc_tag_i;
            data_d[alloc_slot]  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s] <= SLOT_FREE;
                mask_q[s]  <= '0;
                rem_q[s]   <= '0;
                tag_q[s]   <= '0;
                data_q[s]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            rem_q       <= rem_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            err_q       <= err_d;
        end
    end

    assign bus.alloc_ready_o = alloc_ready;
    assign bus.alloc_slot_o  = alloc_slot;
    assign bus.rsp_ready_o   = '1;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.out_mask_o    = out_mask_q;
    assign bus.out_data_o    = out_data_q;
    assign bus.out_tag_o     = out_tag_q;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_vx_cache_rsp_collector.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized
// phase, all compared every cycle against a slot-level behavioural model.
module tb_vx_cache_rsp_collector;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TW = 8;
    localparam int SW = 2;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    vx_cache_rsp_collector_if #(.NUM_REQS(NR), .DATA_WIDTH(DW), .NUM_SLOTS(NS), .CORE_TAG_WIDTH(TW)) bus ();

    vx_cache_rsp_collector #(.NUM_REQS(NR), .DATA_WIDTH(DW), .NUM_SLOTS(NS), .CORE_TAG_WIDTH(TW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a slot is busy from alloc until handed to the output register; it is complete
    // once every requested lane has arrived (got == mask).
    bit                m_busy [NS];
    logic [NR-1:0]     m_mask [NS];
    logic [NR-1:0]     m_got  [NS];
    logic [TW-1:0]     m_tag  [NS];
    logic [NR*DW-1:0]  m_line [NS];
    bit                m_ovalid;
    logic [NR-1:0]     m_omask;
    logic [NR*DW-1:0]  m_odata;
    logic [TW-1:0]     m_otag;
    bit                m_err;

    function automatic logic [NR*DW-1:0] laneMask(input logic [NR-1:0] m);
        logic [NR*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) if (m[i]) r[i*DW +: DW] = '1;
        return r;
    endfunction

    function automatic int lowestFree();
        for (int s = 0; s < NS; s++) if (!m_busy[s]) return s;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < NS; s++) begin
            m_busy[s] = 1'b0;
            m_mask[s] = '0;
            m_got[s]  = '0;
            m_tag[s]  = '0;
            m_line[s] = '0;
        end
        m_ovalid = 1'b0;
        m_omask  = '0;
        m_odata  = '0;
        m_otag   = '0;
        m_err    = 1'b0;
    endtask

    task automatic modelStep();
        bit            busyPre [NS];
        logic [NR-1:0] gotPre  [NS];
        int            lowFree;
        int            lowDone;
        int            s;
        lowFree = -1;
        lowDone = -1;
        for (int k = 0; k < NS; k++) begin
            busyPre[k] = m_busy[k];
            gotPre[k]  = m_got[k];
            if (!m_busy[k] && lowFree < 0) lowFree = k;
            if (m_busy[k] && m_got[k] == m_mask[k] && lowDone < 0) lowDone = k;
        end
        for (int i = 0; i < NR; i++) begin
            if (bus.rsp_valid_i[i]) begin
                s = int'(bus.rsp_tag_i[i*SW +: SW]);
                if (busyPre[s] && m_mask[s][i] && !gotPre[s][i]) begin
                    m_got[s][i] = 1'b1;
                    m_line[s][i*DW +: DW] = bus.rsp_data_i[i*DW +: DW];
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        if (!m_ovalid || bus.out_ready_i) begin
            if (lowDone >= 0) begin
                m_ovalid        = 1'b1;
                m_omask         = m_mask[lowDone];
                m_otag          = m_tag[lowDone];
                m_odata         = m_line[lowDone] & laneMask(m_mask[lowDone]);
                m_busy[lowDone] = 1'b0;
            end else begin
                m_ovalid = 1'b0;
            end
        end
        if (bus.alloc_valid_i && lowFree >= 0) begin
            m_busy[lowFree] = 1'b1;
            m_mask[lowFree] = bus.alloc_mask_i;
            m_got[lowFree]  = '0;
            m_tag[lowFree]  = bus.alloc_tag_i;
            m_line[lowFree] = '0;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else        modelStep();
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        int lf;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                lf = lowestFree();
                checkOutput("alloc_ready", 128'(bus.alloc_ready_o), 128'(lf >= 0));
                if (lf >= 0) checkOutput("alloc_slot", 128'(bus.alloc_slot_o), 128'(lf));
                checkOutput("out_valid", 128'(bus.out_valid_o), 128'(m_ovalid));
                if (m_ovalid) begin
                    checkOutput("out_mask", 128'(bus.out_mask_o), 128'(m_omask));
                    checkOutput("out_data", 128'(bus.out_data_o), 128'(m_odata));
                    checkOutput("out_tag", 128'(bus.out_tag_o), 128'(m_otag));
                end
                checkOutput("err", 128'(bus.err_o), 128'(m_err));
                checkOutput("rsp_ready", 128'(bus.rsp_ready_o), 128'(4'hF));
            end
        end
    end

    task automatic driveInputs(input logic av, input logic [NR-1:0] am, input logic [TW-1:0] at,
                               input logic [NR-1:0] rv, input logic [NR*DW-1:0] rd,
                               input logic [NR*SW-1:0] rt, input logic ordy);
        bus.alloc_valid_i = av;
        bus.alloc_mask_i  = am;
        bus.alloc_tag_i   = at;
        bus.rsp_valid_i   = rv;
        bus.rsp_data_i    = rd;
        bus.rsp_tag_i     = rt;
        bus.out_ready_i   = ordy;
    endtask

    task automatic applyStimulus(input logic av, input logic [NR-1:0] am, input logic [TW-1:0] at,
                                 input logic [NR-1:0] rv, input logic [NR*DW-1:0] rd,
                                 input logic [NR*SW-1:0] rt, input logic ordy);
        @(negedge clk);
        driveInputs(av, am, at, rv, rd, rt, ordy);
    endtask

    task automatic idleCycle(input logic ordy);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, ordy);
    endtask

    task automatic laneRsp(input int lane, input int slot, input logic [DW-1:0] d, input logic ordy);
        logic [NR*DW-1:0] rd;
        logic [NR*SW-1:0] rt;
        rd = '0;
        rt = '0;
        rd[lane*DW +: DW] = d;
        rt[lane*SW +: SW] = SW'(slot);
        applyStimulus(1'b0, '0, '0, NR'(1 << lane), rd, rt, ordy);
    endtask

    // Only legal responses are generated here, so err must stay low throughout.
    task automatic randomCycle();
        logic             av;
        logic [NR-1:0]    am;
        logic [NR-1:0]    rv;
        logic [NR*DW-1:0] rd;
        logic [NR*SW-1:0] rt;
        int               start;
        int               s;
        @(negedge clk);
        av = ($urandom % 3) != 0;
        am = NR'($urandom);
        if (($urandom % 8) == 0) am = '0;
        rv = '0;
        rd = '0;
        rt = '0;
        for (int i = 0; i < NR; i++) begin
            if (($urandom % 2) == 0) begin
                start = int'($urandom % NS);
                for (int k = 0; k < NS; k++) begin
                    s = (start + k) % NS;
                    if (!rv[i] && m_busy[s] && m_mask[s][i] && !m_got[s][i]) begin
                        rv[i] = 1'b1;
                        rt[i*SW +: SW] = SW'(s);
                        rd[i*DW +: DW] = $urandom;
                    end
                end
            end
        end
        driveInputs(av, am, TW'($urandom), rv, rd, rt, ($urandom % 4) != 0);
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        driveInputs(1'b0, '0, '0, '0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Reset while two requests are outstanding and err has been raised.
        applyStimulus(1'b1, 4'b0011, 8'h01, '0, '0, '0, 1'b1);
        applyStimulus(1'b1, 4'b0001, 8'h02, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 4'b0100, '0, 8'h30, 1'b1);
        idleCycle(1'b1);
        checkOutput("pre-reset err", 128'(bus.err_o), 128'(1'b1));
        checkOutput("pre-reset alloc_slot", 128'(bus.alloc_slot_o), 128'(2));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset out_valid", 128'(bus.out_valid_o), 128'(1'b0));
        checkOutput("reset alloc_ready", 128'(bus.alloc_ready_o), 128'(1'b1));
        checkOutput("reset alloc_slot", 128'(bus.alloc_slot_o), 128'(0));
        checkOutput("reset err", 128'(bus.err_o), 128'(1'b0));
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Out-of-order lanes into slot0.
        applyStimulus(1'b1, 4'b1011, 8'h5A, '0, '0, '0, 1'b0);
        checkOutput("t2 alloc_slot", 128'(bus.alloc_slot_o), 128'(0));
        laneRsp(3, 0, 32'h33, 1'b0);
        laneRsp(0, 0, 32'h00, 1'b0);
        laneRsp(1, 0, 32'h11, 1'b0);
        idleCycle(1'b0);
        checkOutput("t2 early valid", 128'(bus.out_valid_o), 128'(1'b0));
        idleCycle(1'b1);
        checkOutput("t2 out_valid", 128'(bus.out_valid_o), 128'(1'b1));
        checkOutput("t2 out_mask", 128'(bus.out_mask_o), 128'(4'b1011));
        checkOutput("t2 out_data", 128'(bus.out_data_o), 128'h00000033_00000000_00000011_00000000);
        checkOutput("t2 out_tag", 128'(bus.out_tag_o), 128'(8'h5A));

        // All slots full, then only slot2 completes.
        for (int k = 0; k < NS; k++) applyStimulus(1'b1, 4'b1111, TW'(8'hA0 + k), '0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 4'b1111, 128'h00000023_00000022_00000021_00000020, 8'hAA, 1'b1);
        checkOutput("t3 full alloc_ready", 128'(bus.alloc_ready_o), 128'(1'b0));
        idleCycle(1'b1);
        checkOutput("t3 done not free", 128'(bus.alloc_ready_o), 128'(1'b0));
        checkOutput("t3 early valid", 128'(bus.out_valid_o), 128'(1'b0));
        idleCycle(1'b1);
        checkOutput("t3 out_tag", 128'(bus.out_tag_o), 128'(8'hA2));
        checkOutput("t3 out_data", 128'(bus.out_data_o), 128'h00000023_00000022_00000021_00000020);
        checkOutput("t3 alloc_ready", 128'(bus.alloc_ready_o), 128'(1'b1));
        checkOutput("t3 alloc_slot", 128'(bus.alloc_slot_o), 128'(2));

        // Slots 1 and 3 complete together under output backpressure.
        applyStimulus(1'b0, '0, '0, 4'b1111, 128'h00000033_00000032_00000011_00000010, 8'hF5, 1'b0);
        applyStimulus(1'b0, '0, '0, 4'b1111, 128'h00000013_00000012_00000031_00000030, 8'h5F, 1'b0);
        idleCycle(1'b0);
        checkOutput("t4 early valid", 128'(bus.out_valid_o), 128'(1'b0));
        for (int k = 0; k < 5; k++) begin
            idleCycle(1'b0);
            checkOutput("t4 hold valid", 128'(bus.out_valid_o), 128'(1'b1));
            checkOutput("t4 hold tag", 128'(bus.out_tag_o), 128'(8'hA1));
            checkOutput("t4 hold data", 128'(bus.out_data_o), 128'h00000013_00000012_00000011_00000010);
        end
        idleCycle(1'b1);
        checkOutput("t4 release tag", 128'(bus.out_tag_o), 128'(8'hA1));
        idleCycle(1'b1);
        checkOutput("t4 next valid", 128'(bus.out_valid_o), 128'(1'b1));
        checkOutput("t4 next tag", 128'(bus.out_tag_o), 128'(8'hA3));
        checkOutput("t4 next data", 128'(bus.out_data_o), 128'h00000033_00000032_00000031_00000030);
        applyStimulus(1'b0, '0, '0, 4'b1111, 128'h00000003_00000002_00000001_00000000, 8'h00, 1'b1);
        repeat (3) idleCycle(1'b1);

        // Zero-mask request completes without any lane response.
        applyStimulus(1'b1, 4'b0000, 8'h77, '0, '0, '0, 1'b1);
        checkOutput("t6 alloc_slot", 128'(bus.alloc_slot_o), 128'(0));
        idleCycle(1'b1);
        checkOutput("t6 early valid", 128'(bus.out_valid_o), 128'(1'b0));
        idleCycle(1'b1);
        checkOutput("t6 out_valid", 128'(bus.out_valid_o), 128'(1'b1));
        checkOutput("t6 out_mask", 128'(bus.out_mask_o), 128'(4'b0000));
        checkOutput("t6 out_data", 128'(bus.out_data_o), 128'(0));
        checkOutput("t6 out_tag", 128'(bus.out_tag_o), 128'(8'h77));

        for (int k = 0; k < 3000; k++) randomCycle();
        idleCycle(1'b1);
        checkOutput("random err", 128'(bus.err_o), 128'(1'b0));
        resetPulse();

        // Stray responses: FREE slot (with a same-cycle alloc into it) and a duplicate lane.
        applyStimulus(1'b1, 4'b0101, 8'hC5, '0, '0, '0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 8'hC6, 4'b0101, 128'h00000000_0000DEAD_00000000_AAAA0000, 8'h10, 1'b0);
        checkOutput("t5 alloc_slot", 128'(bus.alloc_slot_o), 128'(1));
        idleCycle(1'b0);
        checkOutput("t5 err", 128'(bus.err_o), 128'(1'b1));
        laneRsp(0, 0, 32'hBBBB0000, 1'b0);
        applyStimulus(1'b0, '0, '0, 4'b0110, 128'h00000000_22222222_00000061_00000000, 8'h04, 1'b0);
        idleCycle(1'b0);
        checkOutput("t5 early valid", 128'(bus.out_valid_o), 128'(1'b0));
        idleCycle(1'b1);
        checkOutput("t5 slot0 tag", 128'(bus.out_tag_o), 128'(8'hC5));
        checkOutput("t5 slot0 mask", 128'(bus.out_mask_o), 128'(4'b0101));
        checkOutput("t5 slot0 data", 128'(bus.out_data_o), 128'h00000000_22222222_00000000_AAAA0000);
        idleCycle(1'b1);
        checkOutput("t5 slot1 tag", 128'(bus.out_tag_o), 128'(8'hC6));
        checkOutput("t5 slot1 data", 128'(bus.out_data_o), 128'h00000000_00000000_00000061_00000000);
        checkOutput("t5 err sticky", 128'(bus.err_o), 128'(1'b1));
        idleCycle(1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
